// File: rtl/core_mem_sched.sv
// core_mem_sched: shares the single external memory bus between the
// instruction-fetch port and the data (load/store) port.
//
// Each port latches one request. Requests are granted by fixed data priority,
// with a starvation guard that hands the bus to a waiting fetch after
// MAX_DATA_STREAK consecutive data grants. Only one bus transaction is
// outstanding at a time. Read data and a one-cycle ready pulse are routed
// combinationally back to the port that owns the transaction.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   i_insn_start/addr/flush       fetch request pulse, word address, cancel
//   o_insn_ready/data_rd          fetch done pulse and fetched word
//   i_data_start/write/addr       data request pulse, store flag, word address
//   i_data_data_wr/data_be        store data and byte enables
//   o_data_ready/data_data_rd     data done pulse and load data
//   o_bus_start/write/addr        registered one-cycle transaction start
//   o_bus_data_wr/data_be         registered write data and byte enables
//   i_bus_ready/data_rd           slave completion pulse and read data
//   o_perf_*                      grant and fetch-wait counters (optional)
//
// Optional feature: define CORE_MEM_SCHED_PERF_EN to add the 32-bit
// performance counters o_perf_insn_grants, o_perf_data_grants, o_perf_insn_wait.

module core_mem_sched #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned SCW             = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_insn_start,
  input  logic [29:0] i_insn_addr,
  input  logic        i_insn_flush,
  output logic        o_insn_ready,
  output logic [31:0] o_insn_data_rd,
  input  logic        i_data_start,
  input  logic        i_data_write,
  input  logic [29:0] i_data_addr,
  input  logic [31:0] i_data_data_wr,
  input  logic [3:0]  i_data_data_be,
  output logic        o_data_ready,
  output logic [31:0] o_data_data_rd,
`ifdef CORE_MEM_SCHED_PERF_EN
  output logic [31:0] o_perf_insn_grants,
  output logic [31:0] o_perf_data_grants,
  output logic [31:0] o_perf_insn_wait,
`endif
  output logic        o_bus_start,
  output logic        o_bus_write,
  output logic [29:0] o_bus_addr,
  output logic [31:0] o_bus_data_wr,
  output logic [3:0]  o_bus_data_be,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_data_rd
);

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam logic GUARD_EN = (MAX_DATA_STREAK != 0);

  typedef enum logic [1:0] {IDLE, INSN, DATA} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend_i;
  logic             r_pend_d;
  logic [AW-1:0]    r_i_addr;
  logic             r_d_write;
  logic [AW-1:0]    r_d_addr;
  logic [DW-1:0]    r_d_wdata;
  logic [BW-1:0]    r_d_be;
  logic             r_killed;
  logic [SCW-1:0]   r_streak;

  logic             w_insn_busy;
  logic             w_data_busy;
  logic             w_insn_new;
  logic             w_data_new;
  logic             w_insn_cand;
  logic             w_data_cand;
  logic             w_arb;
  logic             w_streak_max;
  logic             w_grant_i;
  logic             w_grant_d;
  logic [AW-1:0]    w_i_addr;
  logic             w_d_write;
  logic [AW-1:0]    w_d_addr;
  logic [DW-1:0]    w_d_wdata;
  logic [BW-1:0]    w_d_be;

  // A port is busy while its transaction is on the bus and not completing;
  // in its completion cycle the port may already present its next request.
  assign w_insn_busy = (r_state == INSN) & ~i_bus_ready;
  assign w_data_busy = (r_state == DATA) & ~i_bus_ready;

  // Starts while pending or busy are protocol violations and are dropped;
  // flush beats a same-cycle fetch start.
  assign w_insn_new  = i_insn_start & ~i_insn_flush & ~r_pend_i & ~w_insn_busy;
  assign w_data_new  = i_data_start & ~r_pend_d & ~w_data_busy;
  assign w_insn_cand = (r_pend_i & ~i_insn_flush) | w_insn_new;
  assign w_data_cand = r_pend_d | w_data_new;

  // Same-cycle bypass: a fresh start is granted directly from the inputs.
  assign w_i_addr  = r_pend_i ? r_i_addr  : i_insn_addr;
  assign w_d_write = r_pend_d ? r_d_write : i_data_write;
  assign w_d_addr  = r_pend_d ? r_d_addr  : i_data_addr;
  assign w_d_wdata = r_pend_d ? r_d_wdata : i_data_data_wr;
  assign w_d_be    = r_pend_d ? r_d_be    : i_data_data_be;

  // Arbitrate when idle or when the current transaction completes.
  assign w_arb        = (r_state == IDLE) | i_bus_ready;
  assign w_streak_max = GUARD_EN & (r_streak == SCW'(MAX_DATA_STREAK));
  assign w_grant_i    = w_arb & w_insn_cand & (~w_data_cand | w_streak_max);
  assign w_grant_d    = w_arb & w_data_cand & ~w_grant_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and zero-latency completion routing
  always_comb begin
    w_state_nxt    = r_state;
    o_insn_ready   = 1'b0;
    o_insn_data_rd = '0;
    o_data_ready   = 1'b0;
    o_data_data_rd = '0;
    if (w_arb) begin
      if (w_grant_i)      w_state_nxt = INSN;
      else if (w_grant_d) w_state_nxt = DATA;
      else                w_state_nxt = IDLE;
    end
    if ((r_state == INSN) && i_bus_ready && !r_killed) begin
      o_insn_ready   = 1'b1;
      o_insn_data_rd = i_bus_data_rd;
    end
    if ((r_state == DATA) && i_bus_ready) begin
      o_data_ready   = 1'b1;
      o_data_data_rd = i_bus_data_rd;
    end
  end

  // Per-port pending requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_i  <= 1'b0;
      r_pend_d  <= 1'b0;
      r_i_addr  <= '0;
      r_d_write <= 1'b0;
      r_d_addr  <= '0;
      r_d_wdata <= '0;
      r_d_be    <= '0;
    end else begin
      if (w_grant_i)         r_pend_i <= 1'b0;
      else if (i_insn_flush) r_pend_i <= 1'b0;
      else if (w_insn_new)   r_pend_i <= 1'b1;
      if (w_insn_new) r_i_addr <= i_insn_addr;

      if (w_grant_d)       r_pend_d <= 1'b0;
      else if (w_data_new) r_pend_d <= 1'b1;
      if (w_data_new) begin
        r_d_write <= i_data_write;
        r_d_addr  <= i_data_addr;
        r_d_wdata <= i_data_data_wr;
        r_d_be    <= i_data_data_be;
      end
    end
  end

  // Starvation streak and flushed-fetch kill flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
      r_killed <= 1'b0;
    end else begin
      if (w_grant_i || !w_insn_cand) r_streak <= '0;
      else if (w_grant_d && !w_streak_max && GUARD_EN) r_streak <= r_streak + SCW'(1);
      r_killed <= w_insn_busy & (r_killed | i_insn_flush);
    end
  end

  // Registered bus request, loaded at the grant edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_bus_start   <= 1'b0;
      o_bus_write   <= 1'b0;
      o_bus_addr    <= '0;
      o_bus_data_wr <= '0;
      o_bus_data_be <= {BW{1'b1}};
    end else begin
      o_bus_start <= w_grant_i | w_grant_d;
      if (w_grant_i) begin
        o_bus_write   <= 1'b0;
        o_bus_addr    <= w_i_addr;
        o_bus_data_wr <= '0;
        o_bus_data_be <= {BW{1'b1}};
      end else if (w_grant_d) begin
        o_bus_write   <= w_d_write;
        o_bus_addr    <= w_d_addr;
        o_bus_data_wr <= w_d_wdata;
        o_bus_data_be <= w_d_be;
      end
    end
  end

`ifdef CORE_MEM_SCHED_PERF_EN
  // Performance counters, wrapping modulo 2**32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_perf_insn_grants <= '0;
      o_perf_data_grants <= '0;
      o_perf_insn_wait   <= '0;
    end else begin
      if (w_grant_i) o_perf_insn_grants <= o_perf_insn_grants + 32'd1;
      if (w_grant_d) o_perf_data_grants <= o_perf_data_grants + 32'd1;
      if (r_pend_i)  o_perf_insn_wait   <= o_perf_insn_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_sched.sv
// Testbench for core_mem_sched: directed scenarios plus randomized traffic
// checked against a request-level reference model.
module tb_core_mem_sched;

  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_insn_start, i_insn_flush;
  logic [29:0] i_insn_addr;
  logic        o_insn_ready;
  logic [31:0] o_insn_data_rd;
  logic        i_data_start, i_data_write;
  logic [29:0] i_data_addr;
  logic [31:0] i_data_data_wr;
  logic [3:0]  i_data_data_be;
  logic        o_data_ready;
  logic [31:0] o_data_data_rd;
  logic        o_bus_start, o_bus_write;
  logic [29:0] o_bus_addr;
  logic [31:0] o_bus_data_wr;
  logic [3:0]  o_bus_data_be;
  logic        i_bus_ready;
  logic [31:0] i_bus_data_rd;
`ifdef CORE_MEM_SCHED_PERF_EN
  logic [31:0] o_perf_insn_grants, o_perf_data_grants, o_perf_insn_wait;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  core_mem_sched #(.MAX_DATA_STREAK(MAXS), .SCW(3)) dut (
    .clk(clk), .rst(rst),
    .i_insn_start(i_insn_start), .i_insn_addr(i_insn_addr), .i_insn_flush(i_insn_flush),
    .o_insn_ready(o_insn_ready), .o_insn_data_rd(o_insn_data_rd),
    .i_data_start(i_data_start), .i_data_write(i_data_write), .i_data_addr(i_data_addr),
    .i_data_data_wr(i_data_data_wr), .i_data_data_be(i_data_data_be),
    .o_data_ready(o_data_ready), .o_data_data_rd(o_data_data_rd),
`ifdef CORE_MEM_SCHED_PERF_EN
    .o_perf_insn_grants(o_perf_insn_grants), .o_perf_data_grants(o_perf_data_grants),
    .o_perf_insn_wait(o_perf_insn_wait),
`endif
    .o_bus_start(o_bus_start), .o_bus_write(o_bus_write), .o_bus_addr(o_bus_addr),
    .o_bus_data_wr(o_bus_data_wr), .o_bus_data_be(o_bus_data_be),
    .i_bus_ready(i_bus_ready), .i_bus_data_rd(i_bus_data_rd)
  );

  task automatic clear_inputs();
    i_insn_start = 1'b0; i_insn_addr = '0; i_insn_flush = 1'b0;
    i_data_start = 1'b0; i_data_write = 1'b0; i_data_addr = '0;
    i_data_data_wr = '0; i_data_data_be = '0;
    i_bus_ready = 1'b0; i_bus_data_rd = '0;
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    i_bus_ready = 1'b1; i_bus_data_rd = 32'hFFFF_FFFF;
    @(negedge clk);
    n_chk++; if (o_bus_start !== 1'b0) $display("FAIL reset_bus_start got=%0h exp=0", o_bus_start); else n_pass++;
    n_chk++; if (o_bus_data_be !== 4'hF) $display("FAIL reset_bus_be got=%0h exp=f", o_bus_data_be); else n_pass++;
    n_chk++; if (o_bus_addr !== 30'h0 || o_bus_write !== 1'b0 || o_bus_data_wr !== 32'h0)
      $display("FAIL reset_bus_fields got=%0h/%0h/%0h exp=0/0/0", o_bus_addr, o_bus_write, o_bus_data_wr); else n_pass++;
    n_chk++; if (o_insn_ready !== 1'b0 || o_data_ready !== 1'b0 || o_data_data_rd !== 32'h0)
      $display("FAIL reset_ready got=%0h/%0h/%0h exp=0/0/0", o_insn_ready, o_data_ready, o_data_data_rd); else n_pass++;
    next_cycle();
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    i_insn_start = 1'b1; i_insn_addr = 30'h100;
    next_cycle();
    i_insn_start = 1'b0;
    @(negedge clk);
    n_chk++; if (o_bus_start !== 1'b1) $display("FAIL fetch_bus_start got=%0h exp=1", o_bus_start); else n_pass++;
    n_chk++; if (o_bus_addr !== 30'h100 || o_bus_write !== 1'b0 || o_bus_data_be !== 4'hF)
      $display("FAIL fetch_bus_req got=%0h/%0h/%0h exp=100/0/f", o_bus_addr, o_bus_write, o_bus_data_be); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b1; i_bus_data_rd = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++; if (o_insn_ready !== 1'b1 || o_insn_data_rd !== 32'hDEAD_BEEF)
      $display("FAIL fetch_ready got=%0h/%0h exp=1/deadbeef", o_insn_ready, o_insn_data_rd); else n_pass++;
    n_chk++; if (o_data_ready !== 1'b0 || o_bus_start !== 1'b0)
      $display("FAIL fetch_other got=%0h/%0h exp=0/0", o_data_ready, o_bus_start); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b0; i_bus_data_rd = 32'h0;
    @(negedge clk);
    n_chk++; if (o_insn_ready !== 1'b0 || o_insn_data_rd !== 32'h0 || o_bus_start !== 1'b0)
      $display("FAIL fetch_after got=%0h/%0h/%0h exp=0/0/0", o_insn_ready, o_insn_data_rd, o_bus_start); else n_pass++;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    i_insn_start = 1'b1; i_insn_addr = 30'h200;
    i_data_start = 1'b1; i_data_write = 1'b1; i_data_addr = 30'h300;
    i_data_data_wr = 32'h55AA_55AA; i_data_data_be = 4'b0011;
    next_cycle();
    i_insn_start = 1'b0; i_data_start = 1'b0;
    @(negedge clk);
    n_chk++; if (o_bus_start !== 1'b1 || o_bus_write !== 1'b1 || o_bus_addr !== 30'h300 ||
                 o_bus_data_wr !== 32'h55AA_55AA || o_bus_data_be !== 4'b0011)
      $display("FAIL simul_data_first got=%0h/%0h/%0h/%0h/%0h exp=1/1/300/55aa55aa/3",
               o_bus_start, o_bus_write, o_bus_addr, o_bus_data_wr, o_bus_data_be); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b1; i_bus_data_rd = 32'h1234_5678;
    @(negedge clk);
    n_chk++; if (o_data_ready !== 1'b1 || o_data_data_rd !== 32'h1234_5678 || o_insn_ready !== 1'b0)
      $display("FAIL simul_data_ready got=%0h/%0h/%0h exp=1/12345678/0", o_data_ready, o_data_data_rd, o_insn_ready); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (o_bus_start !== 1'b1 || o_bus_addr !== 30'h200 || o_bus_write !== 1'b0 ||
                 o_bus_data_be !== 4'hF || o_bus_data_wr !== 32'h0)
      $display("FAIL simul_insn_next got=%0h/%0h/%0h/%0h/%0h exp=1/200/0/f/0",
               o_bus_start, o_bus_addr, o_bus_write, o_bus_data_be, o_bus_data_wr); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b1; i_bus_data_rd = 32'hCAFE_F00D;
    @(negedge clk);
    n_chk++; if (o_insn_ready !== 1'b1 || o_insn_data_rd !== 32'hCAFE_F00D)
      $display("FAIL simul_insn_ready got=%0h/%0h exp=1/cafef00d", o_insn_ready, o_insn_data_rd); else n_pass++;
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  // Fetch waits while the data port keeps re-requesting at each completion.
  task automatic test_streak();
    logic [29:0] q[$];
    logic [29:0] exp_seq [7];
    logic [29:0] last_addr;
    bit ready_next;
    int k;
    exp_seq = '{30'h10, 30'h11, 30'h12, 30'h13, 30'h400, 30'h14, 30'h15};
    ready_next = 1'b0; k = 1; last_addr = '0;
    i_insn_start = 1'b1; i_insn_addr = 30'h400;
    i_data_start = 1'b1; i_data_write = 1'b0; i_data_addr = 30'h10; i_data_data_be = 4'hF;
    next_cycle();
    for (int c = 0; c < 24; c++) begin
      i_insn_start = 1'b0; i_data_start = 1'b0; i_bus_ready = 1'b0;
      if (ready_next) begin
        i_bus_ready = 1'b1; i_bus_data_rd = $urandom;
        if (last_addr != 30'h400 && k < 6) begin
          i_data_start = 1'b1; i_data_addr = 30'h10 + 30'(k); k++;
        end
        ready_next = 1'b0;
      end
      if (o_bus_start === 1'b1) begin
        q.push_back(o_bus_addr); last_addr = o_bus_addr; ready_next = 1'b1;
      end
      next_cycle();
    end
    clear_inputs();
    n_chk++; if (q.size() != 7) $display("FAIL streak_grant_count got=%0d exp=7", q.size()); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      if (i < q.size()) begin
        n_chk++; if (q[i] !== exp_seq[i]) $display("FAIL streak_order[%0d] got=%0h exp=%0h", i, q[i], exp_seq[i]); else n_pass++;
      end
    end
    next_cycle();
  endtask

  task automatic test_flush();
    i_insn_start = 1'b1; i_insn_addr = 30'h500;
    next_cycle();
    i_insn_start = 1'b0;
    n_chk++; if (o_bus_start !== 1'b1 || o_bus_addr !== 30'h500)
      $display("FAIL flush_insn_issue got=%0h/%0h exp=1/500", o_bus_start, o_bus_addr); else n_pass++;
    i_insn_flush = 1'b1;
    i_data_start = 1'b1; i_data_write = 1'b0; i_data_addr = 30'h600; i_data_data_be = 4'hF;
    next_cycle();
    i_insn_flush = 1'b0; i_data_start = 1'b0;
    i_bus_ready = 1'b1; i_bus_data_rd = 32'h1111_1111;
    @(negedge clk);
    n_chk++; if (o_insn_ready !== 1'b0 || o_insn_data_rd !== 32'h0 || o_data_ready !== 1'b0)
      $display("FAIL flush_suppress got=%0h/%0h/%0h exp=0/0/0", o_insn_ready, o_insn_data_rd, o_data_ready); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (o_bus_start !== 1'b1 || o_bus_addr !== 30'h600 || o_bus_write !== 1'b0)
      $display("FAIL flush_data_next got=%0h/%0h/%0h exp=1/600/0", o_bus_start, o_bus_addr, o_bus_write); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b1; i_bus_data_rd = 32'h2222_2222;
    @(negedge clk);
    n_chk++; if (o_data_ready !== 1'b1 || o_data_data_rd !== 32'h2222_2222)
      $display("FAIL flush_data_ready got=%0h/%0h exp=1/22222222", o_data_ready, o_data_data_rd); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b0;
    i_insn_start = 1'b1; i_insn_addr = 30'h510;
    next_cycle();
    i_insn_start = 1'b0;
    next_cycle();
    i_bus_ready = 1'b1; i_bus_data_rd = 32'h3333_3333;
    @(negedge clk);
    n_chk++; if (o_insn_ready !== 1'b1 || o_insn_data_rd !== 32'h3333_3333)
      $display("FAIL flush_kill_cleared got=%0h/%0h exp=1/33333333", o_insn_ready, o_insn_data_rd); else n_pass++;
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int starts;
    i_data_start = 1'b1; i_data_write = 1'b1; i_data_addr = 30'h700;
    i_data_data_wr = 32'hAAAA_5555; i_data_data_be = 4'b1100;
    next_cycle();
    i_data_start = 1'b0;
    n_chk++; if (o_bus_start !== 1'b1 || o_bus_write !== 1'b1)
      $display("FAIL rstmid_issue got=%0h/%0h exp=1/1", o_bus_start, o_bus_write); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (o_bus_start !== 1'b0 || o_bus_write !== 1'b0 || o_bus_addr !== 30'h0 ||
                 o_bus_data_wr !== 32'h0 || o_bus_data_be !== 4'hF || o_data_ready !== 1'b0)
      $display("FAIL rstmid_outputs got=%0h/%0h/%0h/%0h/%0h/%0h exp=0/0/0/0/f/0",
               o_bus_start, o_bus_write, o_bus_addr, o_bus_data_wr, o_bus_data_be, o_data_ready); else n_pass++;
    next_cycle();
    rst = 1'b0;
    i_bus_ready = 1'b1; i_bus_data_rd = 32'h4444_4444;
    @(negedge clk);
    n_chk++; if (o_data_ready !== 1'b0 || o_insn_ready !== 1'b0 || o_data_data_rd !== 32'h0)
      $display("FAIL rstmid_no_ready got=%0h/%0h/%0h exp=0/0/0", o_data_ready, o_insn_ready, o_data_data_rd); else n_pass++;
    next_cycle();
    i_bus_ready = 1'b0;
    starts = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_bus_start === 1'b1) starts++;
      next_cycle();
    end
    n_chk++; if (starts != 0) $display("FAIL rstmid_quiet got=%0d exp=0", starts); else n_pass++;
  endtask

  task automatic test_duplicate();
    int n_bs, n_rdy;
    bit ready_next;
    logic [29:0] first_addr;
    n_bs = 0; n_rdy = 0; ready_next = 1'b0; first_addr = '0;
    i_data_start = 1'b1; i_data_write = 1'b0; i_data_addr = 30'h800; i_data_data_be = 4'hF;
    next_cycle();
    for (int c = 0; c < 8; c++) begin
      i_data_start = (c == 0);
      i_data_addr  = 30'h801;
      i_bus_ready  = ready_next;
      ready_next   = 1'b0;
      if (o_bus_start === 1'b1) begin
        if (n_bs == 0) first_addr = o_bus_addr;
        n_bs++; ready_next = 1'b1;
      end
      @(negedge clk);
      if (o_data_ready === 1'b1) n_rdy++;
      next_cycle();
    end
    clear_inputs();
    n_chk++; if (n_bs != 1 || n_rdy != 1) $display("FAIL dup_counts got=%0d/%0d exp=1/1", n_bs, n_rdy); else n_pass++;
    n_chk++; if (first_addr !== 30'h800) $display("FAIL dup_addr got=%0h exp=800", first_addr); else n_pass++;
  endtask

  // Request-level reference: each port holds at most one waiting request;
  // owner is the port currently on the bus (0 none, 1 fetch, 2 data).
  typedef struct packed {
    logic        v;
    logic        w;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } req_t;

  task automatic test_random();
    req_t pi, pd, ri, rd, nb;
    int owner, streak, winner, cnt;
    bit killed, busy, bstart, take_i, take_d, ic, dc, done_ok;
    bit exp_ir, exp_dr;
    logic [31:0] exp_ird, exp_drd;
    rst = 1'b1; clear_inputs();
    next_cycle();
    rst = 1'b0;
    pi = '0; pd = '0; owner = 0; streak = 0; killed = 1'b0;
    nb = '{v:1'b0, w:1'b0, a:30'h0, d:32'h0, be:4'hF}; bstart = 1'b0;
    busy = 1'b0; cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      // bus slave plus random port traffic
      if (o_bus_start === 1'b1) begin busy = 1'b1; cnt = $urandom_range(1, 3); i_bus_ready = 1'b0; end
      else if (busy) begin cnt--; i_bus_ready = (cnt == 0); if (cnt == 0) busy = 1'b0; end
      else i_bus_ready = ($urandom_range(0, 7) == 0);
      i_bus_data_rd  = $urandom;
      i_insn_start   = ($urandom_range(0, 3) == 0);
      i_insn_addr    = 30'($urandom);
      i_insn_flush   = ($urandom_range(0, 15) == 0);
      i_data_start   = ($urandom_range(0, 2) == 0);
      i_data_write   = 1'($urandom);
      i_data_addr    = 30'($urandom);
      i_data_data_wr = $urandom;
      i_data_data_be = 4'($urandom);
      @(negedge clk);
      exp_ir  = (owner == 1) && i_bus_ready && !killed;
      exp_dr  = (owner == 2) && i_bus_ready;
      exp_ird = exp_ir ? i_bus_data_rd : 32'h0;
      exp_drd = exp_dr ? i_bus_data_rd : 32'h0;
      n_chk++; if (o_insn_ready !== exp_ir || o_insn_data_rd !== exp_ird)
        $display("FAIL rand_insn_ready c=%0d got=%0h/%0h exp=%0h/%0h", c, o_insn_ready, o_insn_data_rd, exp_ir, exp_ird); else n_pass++;
      n_chk++; if (o_data_ready !== exp_dr || o_data_data_rd !== exp_drd)
        $display("FAIL rand_data_ready c=%0d got=%0h/%0h exp=%0h/%0h", c, o_data_ready, o_data_data_rd, exp_dr, exp_drd); else n_pass++;
      n_chk++; if (o_bus_start !== bstart || o_bus_write !== nb.w || o_bus_addr !== nb.a ||
                   o_bus_data_wr !== nb.d || o_bus_data_be !== nb.be)
        $display("FAIL rand_bus c=%0d got=%0h/%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h/%0h", c,
                 o_bus_start, o_bus_write, o_bus_addr, o_bus_data_wr, o_bus_data_be,
                 bstart, nb.w, nb.a, nb.d, nb.be); else n_pass++;
      // advance the reference by one clock
      done_ok = (owner != 0) && i_bus_ready;
      take_i = i_insn_start && !i_insn_flush && !pi.v && !(owner == 1 && !i_bus_ready);
      take_d = i_data_start && !pd.v && !(owner == 2 && !i_bus_ready);
      ri = pi.v ? pi : '{v:1'b1, w:1'b0, a:i_insn_addr, d:32'h0, be:4'hF};
      rd = pd.v ? pd : '{v:1'b1, w:i_data_write, a:i_data_addr, d:i_data_data_wr, be:i_data_data_be};
      ic = (pi.v && !i_insn_flush) || take_i;
      dc = pd.v || take_d;
      winner = 0;
      if (owner == 0 || done_ok) begin
        if (ic && (!dc || (MAXS != 0 && streak == int'(MAXS)))) winner = 1;
        else if (dc) winner = 2;
        owner = winner;
      end
      if (winner == 1 || !ic) streak = 0;
      else if (winner == 2 && streak < int'(MAXS)) streak++;
      killed = (owner == 1 && !done_ok && !(winner == 1)) ? (killed || i_insn_flush) : 1'b0;
      if (winner == 1) pi.v = 1'b0;
      else if (i_insn_flush) pi.v = 1'b0;
      else if (take_i) pi = ri;
      if (winner == 2) pd.v = 1'b0;
      else if (take_d) pd = rd;
      bstart = (winner != 0);
      if (winner == 1) nb = '{v:1'b0, w:1'b0, a:ri.a, d:32'h0, be:4'hF};
      if (winner == 2) nb = '{v:1'b0, w:rd.w, a:rd.a, d:rd.d, be:rd.be};
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_streak();
    test_flush();
    test_reset_mid();
    test_duplicate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
